// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_ex_stage_pkg                                                 |
// | Purpose  : Shared types and constants for the ID/EX stage. Holds the       |
// |            opcode map, the FSM state encoding, the control-bundle struct   |
// |            with its BUBBLE value, the default drain length, and a helper   |
// |            that gives the drain counter's load value.                      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package id_ex_stage_pkg;

   // Opcode map shared with the decode control unit
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // Halt-drain FSM encoding
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Default drain length. Legal values are 1..15, which fit the 4-bit counter.
   localparam int DEFAULT_DRAIN_CYCLES = 3;
   localparam int CNT_W                = 4;

   // Control bundle carried from ID into EX
   typedef struct packed {
      logic regWrite;
      logic memToReg;
      logic memRead;
      logic memWrite;
      logic ALUsrc;
      logic regDst;
      logic noDest;
   } ctrl_t;

   // A bubble carries no side effects
   localparam ctrl_t BUBBLE = '0;

   // Counter load value on entry to DRAIN. The counter counts down to 0, so
   // DRAIN lasts exactly n cycles.
   function automatic logic [CNT_W-1:0] drain_init(input int n);
      return CNT_W'(n - 1);
   endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_ex_if                                                        |
// | Purpose  : Bundles the ID-side inputs and EX-side outputs of the ID/EX     |
// |            stage.                                                          |
// | Ports    : master - drives id_*, observes ex_*, stall and halted           |
// |            slave  - the stage itself: consumes id_*, produces ex_*,        |
// |                     stall and halted                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   // ID side
   logic              id_valid;
   logic              id_flush;
   logic [5:0]        id_opcode;
   logic              id_regWrite;
   logic              id_memToReg;
   logic              id_memRead;
   logic              id_memWrite;
   logic              id_ALUsrc;
   logic              id_regDst;
   logic              id_noDest;
   logic              id_FIM;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic [REG_W-1:0]  id_rd;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic [DATA_W-1:0] id_imm;
   logic [DATA_W-1:0] id_pc4;

   // EX side
   logic              ex_valid;
   logic [5:0]        ex_opcode;
   logic              ex_regWrite;
   logic              ex_memToReg;
   logic              ex_memRead;
   logic              ex_memWrite;
   logic              ex_ALUsrc;
   logic              ex_regDst;
   logic              ex_noDest;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [DATA_W-1:0] ex_rdata1;
   logic [DATA_W-1:0] ex_rdata2;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] ex_pc4;

   // Pipeline status
   logic              stall;
   logic              halted;

   modport master (
      output id_valid, id_flush, id_opcode,
             id_regWrite, id_memToReg, id_memRead, id_memWrite,
             id_ALUsrc, id_regDst, id_noDest, id_FIM,
             id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
      input  ex_valid, ex_opcode,
             ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
             ex_ALUsrc, ex_regDst, ex_noDest,
             ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
             stall, halted
   );

   modport slave (
      input  id_valid, id_flush, id_opcode,
             id_regWrite, id_memToReg, id_memRead, id_memWrite,
             id_ALUsrc, id_regDst, id_noDest, id_FIM,
             id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
      output ex_valid, ex_opcode,
             ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
             ex_ALUsrc, ex_regDst, ex_noDest,
             ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
             stall, halted
   );
endinterface : id_ex_if
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_detect                                                   |
// | Purpose  : Combinational load-use compare. Flags a valid load in EX whose  |
// |            destination (rt, non-zero) matches either source of the valid  |
// |            instruction in ID. Both sources are compared for every opcode,  |
// |            so the stall is conservative.                                   |
// | Ports    : ex_valid_i, ex_memRead_i, ex_rt_i - load currently in EX        |
// |            id_valid_i, id_rs_i, id_rt_i     - instruction in ID            |
// |            hz_o                             - load-use hazard              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  wire logic             ex_valid_i,
   input  wire logic             ex_memRead_i,
   input  wire logic [REG_W-1:0] ex_rt_i,
   input  wire logic             id_valid_i,
   input  wire logic [REG_W-1:0] id_rs_i,
   input  wire logic [REG_W-1:0] id_rt_i,
   output logic                  hz_o
);

   // r0 is hard-wired zero and never carries a real dependency
   assign hz_o = ex_valid_i & ex_memRead_i & (ex_rt_i != '0) & id_valid_i &
                 ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_ex_stage                                                     |
// | Purpose  : ID/EX pipeline register with load-use stall, flush and a        |
// |            halt-drain FSM (RUN -> DRAIN -> HALTED). Every ex_* output is   |
// |            registered, with one cycle of latency from ID.                  |
// | Ports    : clock - rising-edge clock                                       |
// |            reset - synchronous, active-high                                |
// |            bus   - id_ex_if slave: id_* in, ex_*/stall/halted out          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES  // legal 1..15
) (
   input  wire logic clock,
   input  wire logic reset,
   id_ex_if.slave    bus
);

   // EX-side registers
   logic              ex_valid_q;
   logic [5:0]        ex_opcode_q;
   ctrl_t             ex_ctrl_q;
   logic [REG_W-1:0]  ex_rs_q, ex_rt_q, ex_rd_q;
   logic [DATA_W-1:0] ex_rdata1_q, ex_rdata2_q, ex_imm_q, ex_pc4_q;

   // Halt-drain FSM
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              halted_q;

   logic              hz;
   logic              halt_take;
   logic              load_bubble;
   ctrl_t             id_ctrl;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .ex_valid_i   (ex_valid_q),
      .ex_memRead_i (ex_ctrl_q.memRead),
      .ex_rt_i      (ex_rt_q),
      .id_valid_i   (bus.id_valid),
      .id_rs_i      (bus.id_rs),
      .id_rt_i      (bus.id_rt),
      .hz_o         (hz)
   );

   assign id_ctrl = '{regWrite: bus.id_regWrite, memToReg: bus.id_memToReg,
                      memRead:  bus.id_memRead,  memWrite: bus.id_memWrite,
                      ALUsrc:   bus.id_ALUsrc,   regDst:   bus.id_regDst,
                      noDest:   bus.id_noDest};

   // A HALT starts draining only when it would otherwise be captured. A HALT
   // that is flushed or held by a load-use stall does not count.
   assign halt_take = (state_q == ST_RUN) & ~bus.id_flush & ~hz &
                      bus.id_valid & bus.id_FIM;

   // The captured HALT itself enters EX as a bubble
   assign load_bubble = (state_q != ST_RUN) | bus.id_flush | hz | halt_take;

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_valid_q  <= 1'b0;
         ex_opcode_q <= '0;
         ex_ctrl_q   <= BUBBLE;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_rdata1_q <= '0;
         ex_rdata2_q <= '0;
         ex_imm_q    <= '0;
         ex_pc4_q    <= '0;
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         halted_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (halt_take) begin
                  state_q <= ST_DRAIN;
                  cnt_q   <= drain_init(DRAIN_CYCLES);
               end
            end
            ST_DRAIN: begin
               if (cnt_q == '0) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_HALTED: begin
               halted_q <= 1'b1;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase

         if (load_bubble) begin
            // Specifiers are zeroed too, so a bubble can never match a hazard
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_ctrl_q   <= BUBBLE;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            ex_imm_q    <= '0;
            ex_pc4_q    <= '0;
         end else begin
            ex_valid_q  <= bus.id_valid;
            ex_opcode_q <= bus.id_opcode;
            ex_ctrl_q   <= id_ctrl;
            ex_rs_q     <= bus.id_rs;
            ex_rt_q     <= bus.id_rt;
            ex_rd_q     <= bus.id_rd;
            ex_rdata1_q <= bus.id_rdata1;
            ex_rdata2_q <= bus.id_rdata2;
            ex_imm_q    <= bus.id_imm;
            ex_pc4_q    <= bus.id_pc4;
         end
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_opcode   = ex_opcode_q;
   assign bus.ex_regWrite = ex_ctrl_q.regWrite;
   assign bus.ex_memToReg = ex_ctrl_q.memToReg;
   assign bus.ex_memRead  = ex_ctrl_q.memRead;
   assign bus.ex_memWrite = ex_ctrl_q.memWrite;
   assign bus.ex_ALUsrc   = ex_ctrl_q.ALUsrc;
   assign bus.ex_regDst   = ex_ctrl_q.regDst;
   assign bus.ex_noDest   = ex_ctrl_q.noDest;
   assign bus.ex_rs       = ex_rs_q;
   assign bus.ex_rt       = ex_rt_q;
   assign bus.ex_rd       = ex_rd_q;
   assign bus.ex_rdata1   = ex_rdata1_q;
   assign bus.ex_rdata2   = ex_rdata2_q;
   assign bus.ex_imm      = ex_imm_q;
   assign bus.ex_pc4      = ex_pc4_q;

   // Stall is independent of id_flush
   assign bus.stall       = hz | (state_q != ST_RUN);
   assign bus.halted      = halted_q;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_id_ex_stage                                                  |
// | Purpose  : Directed self-checking bench for id_ex_stage                    |
// |            (DRAIN_CYCLES = 3).                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   // Control-vector bits: {FIM,noDest,regDst,ALUsrc,memWrite,memRead,memToReg,regWrite}
   localparam logic [7:0] C_ADDI  = 8'h11;  // regWrite | ALUsrc
   localparam logic [7:0] C_LW    = 8'h17;  // regWrite | memToReg | memRead | ALUsrc
   localparam logic [7:0] C_RTYPE = 8'h21;  // regWrite | regDst
   localparam logic [7:0] C_BEQ   = 8'h40;  // noDest
   localparam logic [7:0] C_HALT  = 8'hC0;  // FIM | noDest

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_if #(.DATA_W(32), .REG_W(5)) bus ();

   id_ex_stage #(.DATA_W(32), .REG_W(5), .DRAIN_CYCLES(3)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction in ID; the data fields are derived from the specifiers
   task automatic present(input logic [5:0] op, input logic v, input logic [7:0] ctl,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm);
      bus.id_opcode = op;
      bus.id_valid  = v;
      {bus.id_FIM, bus.id_noDest, bus.id_regDst, bus.id_ALUsrc,
       bus.id_memWrite, bus.id_memRead, bus.id_memToReg, bus.id_regWrite} = ctl;
      bus.id_rs     = rs;
      bus.id_rt     = rt;
      bus.id_rd     = rd;
      bus.id_rdata1 = 32'h1000_0000 | {27'd0, rs};
      bus.id_rdata2 = 32'h2000_0000 | {27'd0, rt};
      bus.id_imm    = imm;
      bus.id_pc4    = 32'h0000_4004;
   endtask

   task automatic idle;
      present(6'h00, 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
      bus.id_flush = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      present(OP_ADDI, 1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'h55);
      tick;
      n_tests++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%0h exp=0", bus.ex_valid); end
      n_tests++; if ({bus.ex_regWrite, bus.ex_ALUsrc} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl got=%0h exp=0", {bus.ex_regWrite, bus.ex_ALUsrc}); end
      n_tests++; if (bus.ex_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm got=%0h exp=0", bus.ex_imm); end
      n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0h exp=0", bus.halted); end
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
      rst = 1'b0;
      idle;
      tick;
   endtask

   task automatic test_normal;
      present(OP_ADDI, 1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'h10);
      #1;
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL normal_stall got=%0h exp=0", bus.stall); end
      tick;
      n_tests++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL normal_valid got=%0h exp=1", bus.ex_valid); end
      n_tests++; if ({bus.ex_ALUsrc, bus.ex_regWrite, bus.ex_memRead} !== 3'b110) begin n_fail++; $display("FAIL normal_ctrl got=%0h exp=6", {bus.ex_ALUsrc, bus.ex_regWrite, bus.ex_memRead}); end
      n_tests++; if (bus.ex_imm !== 32'h10) begin n_fail++; $display("FAIL normal_imm got=%0h exp=10", bus.ex_imm); end
      n_tests++; if ({bus.ex_opcode, bus.ex_rs, bus.ex_rt} !== {OP_ADDI, 5'd1, 5'd2}) begin n_fail++; $display("FAIL normal_spec got=%0h exp=%0h", {bus.ex_opcode, bus.ex_rs, bus.ex_rt}, {OP_ADDI, 5'd1, 5'd2}); end
      n_tests++; if (bus.ex_rdata1 !== 32'h1000_0001 || bus.ex_pc4 !== 32'h0000_4004) begin n_fail++; $display("FAIL normal_data got=%0h/%0h exp=10000001/4004", bus.ex_rdata1, bus.ex_pc4); end
      idle;
      tick;
   endtask

   task automatic test_load_use;
      present(OP_LW, 1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'h4);
      tick;
      present(OP_RTYPE, 1'b1, C_RTYPE, 5'd5, 5'd6, 5'd7, 32'h0);
      #1;
      n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0h exp=1", bus.stall); end
      tick;
      n_tests++; if (bus.ex_valid !== 1'b0 || bus.ex_regWrite !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%0h exp=0", {bus.ex_valid, bus.ex_regWrite}); end
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got=%0h exp=0", bus.stall); end
      tick;
      n_tests++; if ({bus.ex_valid, bus.ex_rs, bus.ex_rd, bus.ex_regDst} !== {1'b1, 5'd5, 5'd7, 1'b1}) begin n_fail++; $display("FAIL lu_capture got=%0h exp=%0h", {bus.ex_valid, bus.ex_rs, bus.ex_rd, bus.ex_regDst}, {1'b1, 5'd5, 5'd7, 1'b1}); end
      // Load to r0 never stalls
      present(OP_LW, 1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h4);
      tick;
      present(OP_RTYPE, 1'b1, C_RTYPE, 5'd0, 5'd0, 5'd3, 32'h0);
      #1;
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0_stall got=%0h exp=0", bus.stall); end
      tick;
      n_tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3) begin n_fail++; $display("FAIL lu_r0_capture got=%0h exp=23", {bus.ex_valid, bus.ex_rd}); end
      idle;
      tick;
   endtask

   task automatic test_flush_priority;
      present(OP_LW, 1'b1, C_LW, 5'd2, 5'd3, 5'd0, 32'h8);
      tick;
      present(OP_BEQ, 1'b1, C_BEQ, 5'd3, 5'd4, 5'd0, 32'h20);
      bus.id_flush = 1'b1;
      #1;
      n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got=%0h exp=1", bus.stall); end
      tick;
      n_tests++; if ({bus.ex_valid, bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead, bus.ex_memWrite,
                      bus.ex_ALUsrc, bus.ex_regDst, bus.ex_noDest} !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl got=%0h exp=0", {bus.ex_valid, bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead, bus.ex_memWrite, bus.ex_ALUsrc, bus.ex_regDst, bus.ex_noDest}); end
      n_tests++; if ({bus.ex_opcode, bus.ex_rs, bus.ex_imm} !== '0) begin n_fail++; $display("FAIL flush_fields got=%0h exp=0", {bus.ex_opcode, bus.ex_rs, bus.ex_imm}); end
      idle;
      tick;
   endtask

   task automatic test_stalled_halt;
      present(OP_LW, 1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h0);
      tick;
      present(OP_HALT, 1'b1, C_HALT, 5'd8, 5'd0, 5'd0, 32'h0);
      #1;
      n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL shalt_hz got=%0h exp=1", bus.stall); end
      tick;
      // Stalled HALT did not start DRAIN, so stall drops once the load has moved on
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL shalt_no_drain got=%0h exp=0", bus.stall); end
      tick;
      n_tests++; if (bus.stall !== 1'b1 || bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL shalt_drain got=%0h exp=2", {bus.stall, bus.ex_valid}); end
      n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL shalt_halted got=%0h exp=0", bus.halted); end
      idle;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_halt_drain;
      present(OP_HALT, 1'b1, C_HALT, 5'd0, 5'd0, 5'd0, 32'h0);
      #1;
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL halt_pre_stall got=%0h exp=0", bus.stall); end
      tick;  // edge N: HALT captured
      n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b100) begin n_fail++; $display("FAIL halt_n got=%0h exp=4", {bus.stall, bus.halted, bus.ex_valid}); end
      present(OP_ADDI, 1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'h77);
      tick;  // N+1
      n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b100) begin n_fail++; $display("FAIL halt_n1 got=%0h exp=4", {bus.stall, bus.halted, bus.ex_valid}); end
      tick;  // N+2
      n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b100) begin n_fail++; $display("FAIL halt_n2 got=%0h exp=4", {bus.stall, bus.halted, bus.ex_valid}); end
      tick;  // N+3
      n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b110) begin n_fail++; $display("FAIL halt_n3 got=%0h exp=6", {bus.stall, bus.halted, bus.ex_valid}); end
      for (int i = 0; i < 10; i++) begin
         present((i % 2 == 0) ? OP_RTYPE : OP_HALT, i[0], (i % 2 == 0) ? C_RTYPE : C_HALT,
                 5'(i), 5'(i + 1), 5'(i + 2), 32'(i));
         bus.id_flush = i[1];
         tick;
         n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b110) begin n_fail++; $display("FAIL halt_hold_%0d got=%0h exp=6", i, {bus.stall, bus.halted, bus.ex_valid}); end
      end
      idle;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_drain;
      present(OP_HALT, 1'b1, C_HALT, 5'd0, 5'd0, 5'd0, 32'h0);
      tick;  // enter DRAIN
      present(OP_ADDI, 1'b1, C_ADDI, 5'd4, 5'd9, 5'd0, 32'h33);
      rst = 1'b1;
      tick;
      n_tests++; if ({bus.stall, bus.halted, bus.ex_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_status got=%0h exp=0", {bus.stall, bus.halted, bus.ex_valid}); end
      n_tests++; if ({bus.ex_opcode, bus.ex_imm, bus.ex_regWrite} !== '0) begin n_fail++; $display("FAIL rmid_fields got=%0h exp=0", {bus.ex_opcode, bus.ex_imm, bus.ex_regWrite}); end
      rst = 1'b0;
      tick;
      n_tests++; if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'h33) begin n_fail++; $display("FAIL rmid_resume got=%0h/%0h exp=1/33", bus.ex_valid, bus.ex_imm); end
      idle;
      tick;
   endtask

   initial begin
      idle;
      test_reset;
      test_normal;
      test_load_use;
      test_flush_priority;
      test_stalled_halt;
      test_halt_drain;
      test_reset_mid_drain;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the decode control unit.
- Registers the control bundle, operands and register specifiers into EX.
- Detects load-use hazards: stalls PC and IF/ID, and inserts a bubble.
- Runs a halt-drain state machine when HALT is decoded, so in-flight instructions retire before the core stops.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- REG_W, 5, register specifier width.
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_flush  in  1  kill ID slot; driven by IFflush/branch resolution.
- id_opcode  in  6  decoded opcode.
- id_regWrite, id_memToReg, id_memRead, id_memWrite, id_ALUsrc, id_regDst, id_noDest, id_FIM  in  1 each  control from the decode control unit.
- id_rs, id_rt, id_rd  in  REG_W  register specifiers.
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, extended immediate, PC+4.
- ex_valid  out  1  EX slot valid.
- ex_opcode  out  6  registered opcode.
- ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_regDst, ex_noDest  out  1 each  registered control.
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers.
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data.
- stall  out  1  freeze PC and IF/ID (combinational).
- halted  out  1  core stopped; sticky until reset.

Behaviour:
- All ex_* outputs are registered. Latency from ID to EX is 1 cycle.
- Reset, synchronous: all ex_* = 0, ex_valid = 0, state = RUN, drain counter = 0, halted = 0. Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- Bubble: ex_valid = 0, and all ex_* control and opcode fields = 0. Data and specifier fields also = 0, so specifiers never match a hazard.
- Load-use hazard (combinational):
  - hz = ex_valid & ex_memRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Compare both sources for every opcode; a conservative stall is acceptable.
- stall = hz | (state != RUN). It never depends on id_flush.
- Per-edge update priority:
  1. reset.
  2. state != RUN: load a bubble.
  3. id_flush: load a bubble.
  4. hz: load a bubble. The ID contents are held upstream, so the instruction re-presents next cycle.
  5. Otherwise capture all id_* inputs; ex_valid = id_valid.
- Simultaneous id_flush and hz: flush wins. The bubble is loaded; stall still asserts for that cycle, which is harmless.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when the capture path (priority 5) fires with id_valid & id_FIM. The HALT instruction itself enters EX as a bubble (ex_valid = 0), and counter = DRAIN_CYCLES-1.
  - A flushed or stalled HALT does not trigger DRAIN.
  - DRAIN: counter decrements each cycle. Move to HALTED on the edge where counter == 0.
  - With DRAIN_CYCLES = 1, exactly one DRAIN cycle occurs.
  - HALTED: halted = 1, stall = 1, bubbles continuously. Exit only via reset.
- id_FIM when id_valid = 0 is ignored.
- ex_rdata*, ex_imm and ex_pc4 are pure pass-through registers. No arithmetic or width conversion happens here.

Decomposition:
- Shared package/include, next to the existing opcode include:
  - state encoding constants ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2.
  - default DRAIN_CYCLES.
  - BUBBLE control-vector constant.
- Sub-module: hazard_detect (pure combinational load-use compare, producing hz). It is reused later by the forwarding unit.
- The FSM and register bank stay in id_ex_stage.

Test Plan:
- Normal flow: ADDI with rs = 1, rt = 2, imm = 0x10, id_valid = 1, no hazard -> next cycle ex_valid = 1, ex_ALUsrc = 1, ex_regWrite = 1, ex_imm = 0x10, stall = 0.
- Load-use: LW rt = 5 in EX, then an RTYPE with rs = 5 in ID -> stall = 1 for exactly 1 cycle, then EX holds a bubble. The next edge captures the RTYPE (ex_rs = 5).
  - Repeat with ex_rt = 0 -> no stall.
- Flush priority: id_flush = 1 together with a valid BEQ, and hazard also true -> ex_valid = 0 and all controls 0 next cycle.
- Halt drain (DRAIN_CYCLES = 3): HALT captured at edge N -> stall = 1 from cycle N+1, halted = 1 from edge N+3, held for 10 further cycles while ID inputs toggle.
- Stalled HALT: HALT in ID while hz = 1 -> no DRAIN that cycle. DRAIN starts only when the HALT is actually captured.
- Reset mid-DRAIN: assert reset one cycle after entering DRAIN -> next edge state = RUN, halted = 0, stall = 0, all ex_* = 0.
